univ_shift_register: RTL and testbench

Parametrised universal shift register. It supports:
- left and right logical shift
- rotate in both directions
- arithmetic right shift
- parallel load
- synchronous clear
- clock enable

A shift counter tracks how many bits have moved since the last load or clear. The block pulses word_done each time a full N-bit word has been shifted. It sits between serial links and parallel datapaths as a combined serialiser/deserialiser front end.

---
 rtl/univ_shift_register.sv | 114 +++++++++++
 tb/tb_univ_shift_register.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_register.sv
// Universal shift register: logical/arithmetic shifts, rotates, parallel load and clear,
// with a shift counter that pulses word_done after every N shifts.
module univ_shift_register #(
  parameter int N = 8,
  parameter logic [N-1:0] RESET_VALUE = '0,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [2:0]    mode,
  input  logic          serial_in,
  input  logic [N-1:0]  par_in,
  output logic [N-1:0]  reg_out,
  output logic          serial_out,
  output logic [CW-1:0] shift_count,
  output logic          word_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  logic [N-1:0]  data_reg, data_next;
  logic          sout_reg, sout_next;
  logic [CW-1:0] count_reg, count_next;
  logic          done_reg, done_next;
  logic          is_shift;

  always_comb begin
    data_next  = data_reg;
    sout_next  = sout_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    is_shift   = 1'b0;

    case (mode_e'(mode))
      MODE_SHR: begin
        data_next = {serial_in, data_reg[N-1:1]};
        sout_next = data_reg[0];
        is_shift  = 1'b1;
      end
      MODE_SHL: begin
        data_next = {data_reg[N-2:0], serial_in};
        sout_next = data_reg[N-1];
        is_shift  = 1'b1;
      end
      MODE_ROR: begin
        data_next = {data_reg[0], data_reg[N-1:1]};
        sout_next = data_reg[0];
        is_shift  = 1'b1;
      end
      MODE_ROL: begin
        data_next = {data_reg[N-2:0], data_reg[N-1]};
        sout_next = data_reg[N-1];
        is_shift  = 1'b1;
      end
      MODE_ASR: begin
        data_next = {data_reg[N-1], data_reg[N-1:1]};
        sout_next = data_reg[0];
        is_shift  = 1'b1;
      end
      MODE_LOAD: begin
        data_next  = par_in;
        count_next = '0;
      end
      MODE_CLEAR: begin
        data_next  = RESET_VALUE;
        sout_next  = 1'b0;
        count_next = '0;
      end
      default: ;
    endcase

    // A word boundary restarts the count; load/clear already zeroed it above.
    if (is_shift) begin
      if (count_reg == CW'(N - 1)) begin
        count_next = '0;
        done_next  = 1'b1;
      end else begin
        count_next = count_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg  <= RESET_VALUE;
      sout_reg  <= 1'b0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else if (enable) begin
      data_reg  <= data_next;
      sout_reg  <= sout_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end else begin
      done_reg  <= 1'b0;
    end
  end

  assign reg_out     = data_reg;
  assign serial_out  = sout_reg;
  assign shift_count = count_reg;
  assign word_done   = done_reg;

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: four widths run in lockstep against an arithmetic model,
// plus directed literal checks of the main scenarios.
module tb_univ_shift_register;

  localparam int unsigned NW[4] = '{8, 2, 5, 16};
  localparam int unsigned RV[4] = '{0, 0, 0, 16'hFFFF};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        serial_in = 1'b0;
  logic [15:0] par = 16'h0;

  logic [7:0]  r8;  logic so8;  logic [3:0] sc8;  logic wd8;
  logic [1:0]  r2;  logic so2;  logic [1:0] sc2;  logic wd2;
  logic [4:0]  r5;  logic so5;  logic [2:0] sc5;  logic wd5;
  logic [15:0] r16; logic so16; logic [4:0] sc16; logic wd16;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int unsigned m_reg[4];
  int unsigned m_so[4];
  int unsigned m_tot[4];
  int unsigned m_wd[4];
  int unsigned wd_seen[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  univ_shift_register #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .serial_in(serial_in),
    .par_in(par[7:0]), .reg_out(r8), .serial_out(so8), .shift_count(sc8), .word_done(wd8));
  univ_shift_register #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .serial_in(serial_in),
    .par_in(par[1:0]), .reg_out(r2), .serial_out(so2), .shift_count(sc2), .word_done(wd2));
  univ_shift_register #(.N(5)) dut5 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .serial_in(serial_in),
    .par_in(par[4:0]), .reg_out(r5), .serial_out(so5), .shift_count(sc5), .word_done(wd5));
  univ_shift_register #(.N(16), .RESET_VALUE(16'hFFFF)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .serial_in(serial_in),
    .par_in(par), .reg_out(r16), .serial_out(so16), .shift_count(sc16), .word_done(wd16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register as an unsigned number, shifts as multiply/divide by two.
  function automatic int unsigned model_reg(int unsigned r, int unsigned n, int unsigned md,
                                            int unsigned si, int unsigned p, int unsigned rv);
    int unsigned mask = (32'd1 << n) - 32'd1;
    int unsigned top  = 32'd1 << (n - 1);
    int unsigned lsb  = r % 2;
    int unsigned msb  = r / top;
    case (md)
      1: return r / 2 + si * top;
      2: return (r * 2 + si) & mask;
      3: return r / 2 + lsb * top;
      4: return (r * 2 + msb) & mask;
      5: return r / 2 + msb * top;
      6: return p & mask;
      7: return rv;
      default: return r;
    endcase
  endfunction

  function automatic int unsigned model_so(int unsigned r, int unsigned n, int unsigned md,
                                           int unsigned old_so);
    case (md)
      1, 3, 5: return r % 2;
      2, 4:    return r / (32'd1 << (n - 1));
      7:       return 0;
      default: return old_so;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_reg[k] <= RV[k];
        m_so[k]  <= 0;
        m_tot[k] <= 0;
        m_wd[k]  <= 0;
      end else if (!enable) begin
        m_wd[k] <= 0;
      end else begin
        m_reg[k] <= model_reg(m_reg[k], NW[k], int'(mode), int'(serial_in), int'(par), RV[k]);
        m_so[k]  <= model_so(m_reg[k], NW[k], int'(mode), m_so[k]);
        if (mode >= 3'd1 && mode <= 3'd5) begin
          m_tot[k] <= m_tot[k] + 1;
          m_wd[k]  <= ((m_tot[k] + 1) % NW[k] == 0) ? 1 : 0;
        end else begin
          if (mode >= 3'd6) m_tot[k] <= 0;
          m_wd[k] <= 0;
        end
      end
    end
  end

  task automatic cmp(input int k, input int unsigned r, input int unsigned so,
                     input int unsigned sc, input int unsigned wd);
    chk($sformatf("n%0d_reg", NW[k]), r, m_reg[k]);
    chk($sformatf("n%0d_sout", NW[k]), so, m_so[k]);
    chk($sformatf("n%0d_count", NW[k]), sc, m_tot[k] % NW[k]);
    chk($sformatf("n%0d_done", NW[k]), wd, m_wd[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, r8, so8, sc8, wd8);
      cmp(1, r2, so2, sc2, wd2);
      cmp(2, r5, so5, sc5, wd5);
      cmp(3, r16, so16, sc16, wd16);
      if (wd8)  wd_seen[0] <= wd_seen[0] + 1;
      if (wd2)  wd_seen[1] <= wd_seen[1] + 1;
      if (wd5)  wd_seen[2] <= wd_seen[2] + 1;
      if (wd16) wd_seen[3] <= wd_seen[3] + 1;
    end
  end

  // Starts and ends at a falling edge, so the result of this operation is visible on return.
  task automatic step(input logic [2:0] md, input logic si, input logic [15:0] p, input logic en);
    #1;
    mode = md; serial_in = si; par = p; enable = en;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  des_bits;
    logic [7:0]  ser_exp;
    int unsigned base[4];

    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_reg8", r8, 8'h00);
    chk("rst_reg16", r16, 16'hFFFF);
    chk("rst_count8", sc8, 0);
    chk("rst_done8", wd8, 0);
    reset = 1'b0;

    // Deserialise 1,0,1,1,0,0,1,0 first bit first
    des_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      step(3'b001, des_bits[i], 16'h0, 1'b1);
      chk($sformatf("des_done_%0d", i), wd8, (i == 7) ? 1 : 0);
    end
    chk("des_reg", r8, 8'h4D);
    chk("des_count", sc8, 0);
    chk("model_des_reg", m_reg[0], 8'h4D);
    step(3'b000, 1'b0, 16'h0, 1'b1);
    chk("des_done_drop", wd8, 0);

    // Serialise C3 with a two-cycle hold in the middle
    step(3'b110, 1'b0, 16'h00C3, 1'b1);
    ser_exp = 8'b1100_0011;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 5) begin
        step(3'b000, 1'b0, 16'h0, 1'b1);
      end else begin
        step(3'b010, 1'b0, 16'h0, 1'b1);
        chk($sformatf("ser_sout_%0d", i), so8, ser_exp[7 - ((i < 4) ? i : i - 2)]);
      end
      chk($sformatf("ser_done_%0d", i), wd8, (i == 9) ? 1 : 0);
    end
    chk("ser_reg", r8, 8'h00);

    // Rotates and arithmetic shift
    step(3'b110, 1'b0, 16'h0081, 1'b1);
    step(3'b011, 1'b0, 16'h0, 1'b1);
    chk("ror_reg", r8, 8'hC0);
    chk("ror_sout", so8, 1);
    step(3'b100, 1'b0, 16'h0, 1'b1);
    step(3'b100, 1'b0, 16'h0, 1'b1);
    chk("rol_reg", r8, 8'h03);
    step(3'b110, 1'b0, 16'h0090, 1'b1);
    step(3'b101, 1'b0, 16'h0, 1'b1);
    step(3'b101, 1'b0, 16'h0, 1'b1);
    chk("asr_reg", r8, 8'hE4);
    chk("asr_sout", so8, 0);
    chk("model_asr_reg", m_reg[0], 8'hE4);

    // Enable gating, then a load on the wrap edge
    for (int i = 0; i < 5; i++) step(3'b001, 1'b1, 16'h0, 1'b0);
    chk("gate_reg", r8, 8'hE4);
    chk("gate_count", sc8, 2);
    step(3'b111, 1'b0, 16'h0, 1'b1);
    chk("clr_reg16", r16, 16'hFFFF);
    for (int i = 0; i < 7; i++) step(3'b001, 1'b1, 16'h0, 1'b1);
    chk("wrap_pre_count", sc8, 7);
    step(3'b110, 1'b0, 16'h003C, 1'b1);
    chk("wrap_load_reg", r8, 8'h3C);
    chk("wrap_load_count", sc8, 0);
    chk("wrap_load_done", wd8, 0);

    // Asynchronous reset mid-word, checked before the next clock edge
    step(3'b110, 1'b0, 16'h00A5, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b001, 1'b0, 16'h0, 1'b1);
    chk("mid_count", sc8, 3);
    chk("mid_sout", so8, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_reg8", r8, 8'h00);
    chk("arst_sout8", so8, 0);
    chk("arst_count8", sc8, 0);
    chk("arst_done8", wd8, 0);
    chk("arst_reg16", r16, 16'hFFFF);
    @(negedge clk);
    reset = 1'b0;

    // Width sweep: word_done rate for each instance
    step(3'b111, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) base[k] = wd_seen[k];
    for (int i = 0; i < 40; i++) step(3'b001, logic'(i % 2 ^ (i / 4) % 2), 16'h0, 1'b1);
    step(3'b000, 1'b0, 16'h0, 1'b1);
    chk("sweep_pulses_n8", wd_seen[0] - base[0], 5);
    chk("sweep_pulses_n2", wd_seen[1] - base[1], 20);
    chk("sweep_pulses_n5", wd_seen[2] - base[2], 8);
    chk("sweep_pulses_n16", wd_seen[3] - base[3], 2);

    // Mixed shift modes within words, then clear
    step(3'b110, 1'b0, 16'hB62D, 1'b1);
    for (int i = 0; i < 23; i++) step(3'(1 + i % 5), logic'((i / 2) % 2), 16'h0, 1'b1);
    step(3'b111, 1'b0, 16'h0, 1'b1);
    chk("final_clr_reg16", r16, 16'hFFFF);
    chk("final_clr_reg8", r8, 8'h00);
    step(3'b000, 1'b0, 16'h0, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
